// File: rtl/smpu_pkg.sv
// rtl/smpu_pkg.sv - register map, field positions and helpers for the system MPU
package smpu_pkg;

    localparam logic [5:0] WADDR_CTRL   = 6'h20;
    localparam logic [5:0] WADDR_STATUS = 6'h21;
    localparam logic [5:0] WADDR_FAULT  = 6'h22;

    localparam int ENT_EN       = 0;
    localparam int ENT_PRIV     = 1;
    localparam int ENT_RO       = 2;
    localparam int ENT_NX       = 3;
    localparam int ENT_SIZE_LSB = 7;
    localparam int SIZE_W       = 5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_LOCK   = 2;

    localparam int ST_VLD       = 0;
    localparam int ST_OVF       = 1;
    localparam int ST_IDX_LSB   = 4;
    localparam int ST_HWRITE    = 8;
    localparam int ST_HPROT_LSB = 9;

    // Index width, never below one bit so a single-entry build still has a field.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic [31:0] entry_wmask(input int min_gran);
        return (32'hFFFF_FFFF << min_gran) | 32'h0000_0F8F;
    endfunction

endpackage

// File: rtl/smpu_region_match.sv
// rtl/smpu_region_match.sv - address/attribute match for one MPU region
module smpu_region_match
    import smpu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MIN_GRAN = 12
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic              priv_i,
    input  logic              ro_i,
    input  logic              nx_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [1:0]        hprot_i,
    input  logic              hwrite_i,
    output logic              hit_o,
    output logic              viol_o
);

    logic [5:0]        s_plus1;
    logic [5:0]        sz;
    logic [ADDR_W-1:0] mask;

    assign s_plus1 = {1'b0, size_i} + 6'd1;
    assign sz      = (s_plus1 > 6'(MIN_GRAN)) ? s_plus1 : 6'(MIN_GRAN);

    // Only bits at or above log2(region size) take part in the compare.
    always_comb begin
        mask = '0;
        for (int b = 0; b < ADDR_W; b++) mask[b] = (b >= int'(sz));
    end

    assign hit_o  = en_i & (((haddr_i ^ base_i) & mask) == '0);
    assign viol_o = (priv_i & ~hprot_i[1]) | (ro_i & hwrite_i) | (nx_i & ~hprot_i[0]);

endmodule

// File: rtl/smpu_region_ctrl.sv
// rtl/smpu_region_ctrl.sv - APB-programmed region MPU with deny, fault capture and irq
module smpu_region_ctrl
    import smpu_pkg::*;
#(
    parameter int NUM_ENTRY = 8,
    parameter int ADDR_W    = 32,
    parameter int MIN_GRAN  = 12
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:2]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [ADDR_W-1:0] biu_pad_haddr,
    input  logic [3:0]        biu_pad_hprot,
    input  logic              biu_pad_hwrite,
    input  logic              biu_pad_hvld,
    output logic              smpu_deny,
    output logic              smpu_irq
);

    localparam int          IDX_W       = clog2(NUM_ENTRY);
    localparam logic [31:0] ENTRY_WMASK = entry_wmask(MIN_GRAN);

    logic [31:0]          entry_q [NUM_ENTRY];
    logic                 ctrl_en_q, irq_en_q, lock_q;
    logic [31:0]          prdata_q, rdata;
    logic                 fault_vld_q, fault_vld_d, ovf_q, ovf_d;
    logic [IDX_W-1:0]     fidx_q, fidx_d, vidx;
    logic                 fwrite_q, fwrite_d;
    logic [1:0]           fprot_q, fprot_d;
    logic [ADDR_W-1:0]    faddr_q, faddr_d;
    logic [NUM_ENTRY-1:0] ent_dec, hit, attr_viol, viol;
    logic                 ent_sel, ctrl_sel, stat_sel, fault_sel, mapped;
    logic                 apb_wr, apb_rd_setup, w1c_vld, w1c_ovf;
    logic                 unused_hprot;

    assign unused_hprot = ^biu_pad_hprot[3:2];

    always_comb begin
        ent_dec = '0;
        for (int i = 0; i < NUM_ENTRY; i++)
            ent_dec[i] = (paddr[7:6] == 2'b00) && (paddr[5:2] == 4'(i));
    end

    assign ent_sel      = |ent_dec;
    assign ctrl_sel     = (paddr == WADDR_CTRL);
    assign stat_sel     = (paddr == WADDR_STATUS);
    assign fault_sel    = (paddr == WADDR_FAULT);
    assign mapped       = ent_sel | ctrl_sel | stat_sel | fault_sel;
    assign apb_wr       = psel & penable & pwrite;
    assign apb_rd_setup = psel & ~penable & ~pwrite;
    assign w1c_vld      = apb_wr & stat_sel & pwdata[ST_VLD];
    assign w1c_ovf      = apb_wr & stat_sel & pwdata[ST_OVF];

    assign pready  = 1'b1;
    assign pslverr = psel & penable & (~mapped | (lock_q & pwrite & (ent_sel | ctrl_sel)));
    assign prdata  = prdata_q;

    for (genvar g = 0; g < NUM_ENTRY; g++) begin : g_match
        logic [31:0] base32;
        assign base32 = {entry_q[g][31:MIN_GRAN], {MIN_GRAN{1'b0}}};
        smpu_region_match #(.ADDR_W(ADDR_W), .MIN_GRAN(MIN_GRAN)) u_match (
            .en_i     (entry_q[g][ENT_EN]),
            .base_i   (base32[ADDR_W-1:0]),
            .size_i   (entry_q[g][ENT_SIZE_LSB +: SIZE_W]),
            .priv_i   (entry_q[g][ENT_PRIV]),
            .ro_i     (entry_q[g][ENT_RO]),
            .nx_i     (entry_q[g][ENT_NX]),
            .haddr_i  (biu_pad_haddr),
            .hprot_i  (biu_pad_hprot[1:0]),
            .hwrite_i (biu_pad_hwrite),
            .hit_o    (hit[g]),
            .viol_o   (attr_viol[g])
        );
    end

    assign viol = hit & attr_viol;

    // Descending scan so the lowest violating entry is the one left in vidx.
    always_comb begin
        vidx = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--)
            if (viol[i]) vidx = IDX_W'(i);
    end

    assign smpu_deny = ctrl_en_q & biu_pad_hvld & (|viol);
    assign smpu_irq  = fault_vld_q & irq_en_q;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_ENTRY; i++)
            if (ent_dec[i]) rdata = entry_q[i];
        if (ctrl_sel) begin
            rdata[CTRL_EN]     = ctrl_en_q;
            rdata[CTRL_IRQ_EN] = irq_en_q;
            rdata[CTRL_LOCK]   = lock_q;
        end
        if (stat_sel) begin
            rdata[ST_VLD]             = fault_vld_q;
            rdata[ST_OVF]             = ovf_q;
            rdata[ST_IDX_LSB +: 4]    = 4'(fidx_q);
            rdata[ST_HWRITE]          = fwrite_q;
            rdata[ST_HPROT_LSB +: 2]  = fprot_q;
        end
        if (fault_sel) rdata = 32'(faddr_q);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_ENTRY; i++) entry_q[i] <= '0;
            ctrl_en_q <= 1'b0;
            irq_en_q  <= 1'b0;
            lock_q    <= 1'b0;
            prdata_q  <= '0;
        end else begin
            if (apb_wr && !lock_q) begin
                for (int i = 0; i < NUM_ENTRY; i++)
                    if (ent_dec[i]) entry_q[i] <= pwdata & ENTRY_WMASK;
                if (ctrl_sel) begin
                    ctrl_en_q <= pwdata[CTRL_EN];
                    irq_en_q  <= pwdata[CTRL_IRQ_EN];
                    lock_q    <= pwdata[CTRL_LOCK];
                end
            end
            if (apb_rd_setup) prdata_q <= rdata;
        end
    end

    // A W1C of fault_vld in the same cycle as a new fault frees the slot first.
    always_comb begin
        fault_vld_d = fault_vld_q & ~w1c_vld;
        ovf_d       = ovf_q & ~w1c_ovf;
        fidx_d      = fidx_q;
        fwrite_d    = fwrite_q;
        fprot_d     = fprot_q;
        faddr_d     = faddr_q;
        if (smpu_deny) begin
            if (fault_vld_d) begin
                ovf_d = 1'b1;
            end else begin
                fault_vld_d = 1'b1;
                fidx_d      = vidx;
                fwrite_d    = biu_pad_hwrite;
                fprot_d     = biu_pad_hprot[1:0];
                faddr_d     = biu_pad_haddr;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            fault_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            fidx_q      <= '0;
            fwrite_q    <= 1'b0;
            fprot_q     <= '0;
            faddr_q     <= '0;
        end else begin
            fault_vld_q <= fault_vld_d;
            ovf_q       <= ovf_d;
            fidx_q      <= fidx_d;
            fwrite_q    <= fwrite_d;
            fprot_q     <= fprot_d;
            faddr_q     <= faddr_d;
        end
    end

endmodule

// File: tb/tb_smpu_region_ctrl.sv
// tb/tb_smpu_region_ctrl.sv - self-checking bench for smpu_region_ctrl
module tb_smpu_region_ctrl;

    localparam int NUM = 8;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [7:2]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [31:0] haddr;
    logic [3:0]  hprot;
    logic        hwrite, hvld;
    logic        smpu_deny, smpu_irq;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] mdl_entry [NUM];
    logic        mdl_en;

    always #5 pclk = ~pclk;

    smpu_region_ctrl #(.NUM_ENTRY(NUM), .ADDR_W(32), .MIN_GRAN(12)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .biu_pad_haddr(haddr), .biu_pad_hprot(hprot), .biu_pad_hwrite(hwrite),
        .biu_pad_hvld(hvld), .smpu_deny(smpu_deny), .smpu_irq(smpu_irq)
    );

    // All tasks start and end 1 time unit after a rising edge.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a[7:2]; pwdata = d;
        @(posedge pclk); #1 penable = 1'b1;
        #1 err = pslverr;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a[7:2];
        @(posedge pclk); #1 penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic ahb(input logic [31:0] a, input logic [3:0] p, input logic w, output logic d);
        haddr = a; hprot = p; hwrite = w; hvld = 1'b1;
        #2 d = smpu_deny;
        @(posedge pclk); #1 hvld = 1'b0;
    endtask

    task automatic set_entry(input int i, input logic [31:0] v);
        logic e;
        apb_write(8'(4 * i), v, e);
        mdl_entry[i] = v;
    endtask

    // Reference: region size 2^max(S+1,12), first enabled matching entry whose rules are broken.
    function automatic void model(input logic [31:0] a, input logic [3:0] p, input logic w,
                                  output logic deny, output int idx);
        longint unsigned sz, base;
        logic [31:0] e;
        int s;
        deny = 1'b0;
        idx  = 0;
        for (int i = 0; i < NUM; i++) begin
            e = mdl_entry[i];
            s = int'(e[11:7]) + 1;
            if (s < 12) s = 12;
            sz   = 64'd1 << s;
            base = {32'd0, e[31:12], 12'd0};
            if (!deny && e[0] && ({32'd0, a} / sz == base / sz) &&
                ((e[1] && !p[1]) || (e[2] && w) || (e[3] && !p[0]))) begin
                deny = 1'b1;
                idx  = i;
            end
        end
        deny = deny & mdl_en;
    endfunction

    task automatic test_reset();
        logic [31:0] d; logic e;
        n_chk++; if (prdata !== 32'd0) $display("FAIL rst_prdata: got %h exp 0", prdata); else n_pass++;
        n_chk++; if (pslverr !== 1'b0) $display("FAIL rst_pslverr: got %b exp 0", pslverr); else n_pass++;
        n_chk++; if (smpu_irq !== 1'b0) $display("FAIL rst_irq: got %b exp 0", smpu_irq); else n_pass++;
        n_chk++; if (pready !== 1'b1) $display("FAIL rst_pready: got %b exp 1", pready); else n_pass++;
        apb_read(8'h80, d, e);
        n_chk++; if (d !== 32'd0) $display("FAIL rst_ctrl: got %h exp 0", d); else n_pass++;
        apb_read(8'h84, d, e);
        n_chk++; if (d !== 32'd0) $display("FAIL rst_status: got %h exp 0", d); else n_pass++;
        apb_read(8'h00, d, e);
        n_chk++; if (d !== 32'd0) $display("FAIL rst_entry0: got %h exp 0", d); else n_pass++;
    endtask

    task automatic test_priv();
        logic [31:0] d; logic e, dn;
        set_entry(0, 32'h2000_0783);
        apb_write(8'h80, 32'h1, e); mdl_en = 1'b1;
        ahb(32'h2000_8000, 4'b0001, 1'b0, dn);
        n_chk++; if (dn !== 1'b1) $display("FAIL t1_user_deny: got %b exp 1", dn); else n_pass++;
        ahb(32'h2000_8000, 4'b0011, 1'b0, dn);
        n_chk++; if (dn !== 1'b0) $display("FAIL t1_priv_allow: got %b exp 0", dn); else n_pass++;
        apb_read(8'h00, d, e);
        n_chk++; if (d !== 32'h2000_0783) $display("FAIL t1_entry_rb: got %h exp 20000783", d); else n_pass++;
    endtask

    task automatic test_bounds();
        logic e, dn;
        ahb(32'h2001_0000, 4'b0001, 1'b0, dn);
        n_chk++; if (dn !== 1'b0) $display("FAIL t2_outside: got %b exp 0", dn); else n_pass++;
        ahb(32'h2000_FFFC, 4'b0001, 1'b0, dn);
        n_chk++; if (dn !== 1'b1) $display("FAIL t2_top_edge: got %b exp 1", dn); else n_pass++;
        apb_write(8'h80, 32'h0, e); mdl_en = 1'b0;
        ahb(32'h2000_8000, 4'b0001, 1'b0, dn);
        n_chk++; if (dn !== 1'b0) $display("FAIL t2_ctrl_off: got %b exp 0", dn); else n_pass++;
        apb_write(8'h80, 32'h1, e); mdl_en = 1'b1;
        apb_write(8'h84, 32'h3, e);
    endtask

    task automatic test_faults();
        logic [31:0] d; logic e, dn;
        ahb(32'h2000_0100, 4'b0001, 1'b0, dn);
        apb_read(8'h88, d, e);
        n_chk++; if (d !== 32'h2000_0100) $display("FAIL t3_faddr1: got %h exp 20000100", d); else n_pass++;
        apb_read(8'h84, d, e);
        n_chk++; if (d !== 32'h0000_0201) $display("FAIL t3_status1: got %h exp 00000201", d); else n_pass++;
        ahb(32'h2000_0200, 4'b0001, 1'b1, dn);
        apb_read(8'h84, d, e);
        n_chk++; if (d !== 32'h0000_0203) $display("FAIL t3_status2: got %h exp 00000203", d); else n_pass++;
        apb_read(8'h88, d, e);
        n_chk++; if (d !== 32'h2000_0100) $display("FAIL t3_faddr_hold: got %h exp 20000100", d); else n_pass++;
        n_chk++; if (smpu_irq !== 1'b0) $display("FAIL t3_irq_masked: got %b exp 0", smpu_irq); else n_pass++;
        apb_write(8'h80, 32'h3, e);
        n_chk++; if (smpu_irq !== 1'b1) $display("FAIL t3_irq_on: got %b exp 1", smpu_irq); else n_pass++;
        apb_write(8'h84, 32'h3, e);
        n_chk++; if (smpu_irq !== 1'b0) $display("FAIL t3_irq_clr: got %b exp 0", smpu_irq); else n_pass++;
        // Load a fault, then W1C fault_vld in the same cycle as a second fault.
        ahb(32'h2000_0100, 4'b0001, 1'b0, dn);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h21; pwdata = 32'h1;
        @(posedge pclk); #1 penable = 1'b1;
        haddr = 32'h2000_0300; hprot = 4'b0001; hwrite = 1'b0; hvld = 1'b1;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; hvld = 1'b0;
        apb_read(8'h84, d, e);
        n_chk++; if (d[1:0] !== 2'b01) $display("FAIL t3_same_cycle_st: got %b exp 01", d[1:0]); else n_pass++;
        apb_read(8'h88, d, e);
        n_chk++; if (d !== 32'h2000_0300) $display("FAIL t3_same_cycle_addr: got %h exp 20000300", d); else n_pass++;
        apb_write(8'h80, 32'h1, e);
        apb_write(8'h84, 32'h3, e);
    endtask

    task automatic test_priority();
        logic [31:0] d; logic e, dn;
        set_entry(2, 32'h3000_0785);
        set_entry(5, 32'h3000_0789);
        ahb(32'h3000_0040, 4'b0011, 1'b1, dn);
        apb_read(8'h84, d, e);
        n_chk++; if (d[7:4] !== 4'd2) $display("FAIL t4_ro_idx: got %0d exp 2", d[7:4]); else n_pass++;
        apb_write(8'h84, 32'h3, e);
        ahb(32'h3000_0040, 4'b0010, 1'b0, dn);
        apb_read(8'h84, d, e);
        n_chk++; if (d[7:4] !== 4'd5) $display("FAIL t4_nx_idx: got %0d exp 5", d[7:4]); else n_pass++;
        apb_write(8'h84, 32'h3, e);
        ahb(32'h3000_0040, 4'b0010, 1'b1, dn);
        apb_read(8'h84, d, e);
        n_chk++; if (d[7:4] !== 4'd2) $display("FAIL t4_both_idx: got %0d exp 2", d[7:4]); else n_pass++;
        apb_write(8'h84, 32'h3, e);
    endtask

    task automatic test_random();
        logic [31:0] d, a, v; logic e, dn, exp_dn; int exp_idx, k, s;
        logic [3:0] p; logic w;
        for (int i = 0; i < NUM; i++) begin
            v = (32'h2000_0000 + ($urandom_range(0, 15) << 16)) | (32'($urandom_range(11, 17)) << 7)
                | 32'($urandom_range(0, 15));
            set_entry(i, v);
        end
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, NUM - 1);
            s = int'(mdl_entry[k][11:7]) + 1;
            a = {mdl_entry[k][31:12], 12'd0} + ($urandom_range(0, (2 << s) - 1) & 32'hFFFF_FFFC);
            p = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            model(a, p, w, exp_dn, exp_idx);
            ahb(a, p, w, dn);
            n_chk++; if (dn !== exp_dn) $display("FAIL rnd_deny: a=%h got %b exp %b", a, dn, exp_dn); else n_pass++;
            if (exp_dn) begin
                apb_read(8'h84, d, e);
                n_chk++;
                if (d !== ({21'd0, p[1:0], w, 4'(exp_idx), 4'b0001}))
                    $display("FAIL rnd_status: a=%h got %h exp idx %0d", a, d, exp_idx);
                else n_pass++;
                apb_read(8'h88, d, e);
                n_chk++; if (d !== a) $display("FAIL rnd_faddr: got %h exp %h", d, a); else n_pass++;
                apb_write(8'h84, 32'h3, e);
            end
        end
    endtask

    task automatic test_unmapped_reset();
        logic [31:0] d; logic e, dn;
        apb_read(8'h90, d, e);
        n_chk++; if (e !== 1'b1) $display("FAIL t6_unmapped_err: got %b exp 1", e); else n_pass++;
        n_chk++; if (d !== 32'd0) $display("FAIL t6_unmapped_data: got %h exp 0", d); else n_pass++;
        apb_write(8'h20, 32'h1, e);
        n_chk++; if (e !== 1'b1) $display("FAIL t6_entry8_err: got %b exp 1", e); else n_pass++;
        set_entry(0, 32'h2000_0783);
        apb_write(8'h80, 32'h3, e);
        ahb(32'h2000_0000, 4'b0001, 1'b0, dn);
        n_chk++; if (smpu_irq !== 1'b1) $display("FAIL t6_irq_pre: got %b exp 1", smpu_irq); else n_pass++;
        #2 presetn = 1'b0;
        #1;
        n_chk++; if (smpu_irq !== 1'b0) $display("FAIL t6_irq_async: got %b exp 0", smpu_irq); else n_pass++;
        @(posedge pclk); @(negedge pclk) presetn = 1'b1;
        @(posedge pclk); #1;
        for (int i = 0; i < NUM; i++) mdl_entry[i] = 32'd0;
        mdl_en = 1'b0;
        apb_read(8'h84, d, e);
        n_chk++; if (d !== 32'd0) $display("FAIL t6_status_rst: got %h exp 0", d); else n_pass++;
        apb_read(8'h88, d, e);
        n_chk++; if (d !== 32'd0) $display("FAIL t6_faddr_rst: got %h exp 0", d); else n_pass++;
        apb_read(8'h00, d, e);
        n_chk++; if (d !== 32'd0) $display("FAIL t6_entry_rst: got %h exp 0", d); else n_pass++;
    endtask

    task automatic test_lock();
        logic [31:0] d; logic e, dn;
        set_entry(0, 32'h2000_0783);
        apb_write(8'h80, 32'h5, e);
        n_chk++; if (e !== 1'b0) $display("FAIL t5_lock_wr_err: got %b exp 0", e); else n_pass++;
        apb_write(8'h00, 32'h0, e);
        n_chk++; if (e !== 1'b1) $display("FAIL t5_locked_entry_err: got %b exp 1", e); else n_pass++;
        apb_read(8'h00, d, e);
        n_chk++; if (d !== 32'h2000_0783) $display("FAIL t5_entry_kept: got %h exp 20000783", d); else n_pass++;
        apb_write(8'h80, 32'h0, e);
        n_chk++; if (e !== 1'b1) $display("FAIL t5_locked_ctrl_err: got %b exp 1", e); else n_pass++;
        apb_read(8'h80, d, e);
        n_chk++; if (d !== 32'h5) $display("FAIL t5_ctrl_kept: got %h exp 5", d); else n_pass++;
        ahb(32'h2000_0000, 4'b0001, 1'b0, dn);
        n_chk++; if (dn !== 1'b1) $display("FAIL t5_deny: got %b exp 1", dn); else n_pass++;
        apb_write(8'h84, 32'h3, e);
        n_chk++; if (e !== 1'b0) $display("FAIL t5_w1c_err: got %b exp 0", e); else n_pass++;
        apb_read(8'h84, d, e);
        n_chk++; if (d[1:0] !== 2'b00) $display("FAIL t5_w1c: got %b exp 00", d[1:0]); else n_pass++;
    endtask

    initial begin
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        haddr = '0; hprot = '0; hwrite = 1'b0; hvld = 1'b0; mdl_en = 1'b0;
        for (int i = 0; i < NUM; i++) mdl_entry[i] = 32'd0;
        repeat (3) @(posedge pclk);
        @(negedge pclk) presetn = 1'b1;
        @(posedge pclk); #1;
        test_reset();
        test_priv();
        test_bounds();
        test_faults();
        test_priority();
        test_random();
        test_unmapped_reset();
        test_lock();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
